// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP header parser.
package udp_pkg;

  localparam int UDP_HDR_BYTES = 8;
  localparam int SRC_PORT_OFF  = 0;
  localparam int DST_PORT_OFF  = 2;
  localparam int LENGTH_OFF    = 4;
  localparam int CHECKSUM_OFF  = 6;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } parser_state_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] checksum;
  } udp_hdr_t;

endpackage

// File: rtl/udp_header_parser.sv
// Captures the 8-byte UDP header, filters on dst port and passes or drops the payload.
// Optional packet statistics outputs are enabled with `define UDP_PARSER_STATS_EN.
// state | meaning
// HDR   | collecting header bytes 0..7
// FWD   | payload passed through to the forwarder
// DROP  | payload consumed and discarded
module udp_header_parser
  import udp_pkg::*;
#(
  parameter logic [15:0] FILTER_PORT = 16'd5000,
  parameter logic [15:0] MIN_LEN     = 16'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        data_valid_in,
  output logic        ready_out,
  input  logic        ready_in,
  output logic [7:0]  data_out,
  output logic        data_valid_out,
  output logic        header_done,
  output logic        hdr_error,
  output logic        fwd_enable,
  output logic        drop_enable,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] udp_length,
  output logic [15:0] udp_checksum
`ifdef UDP_PARSER_STATS_EN
  ,
  output logic [31:0] pkt_fwd_cnt,
  output logic [31:0] pkt_drop_cnt,
  output logic [31:0] pkt_err_cnt
`endif
);

  parser_state_t state;
  logic [2:0]    hdr_cnt;
  logic [55:0]   hdr_shift;
  logic [15:0]   pay_cnt;
  udp_hdr_t      hdr_next;
  logic          accept;
  logic          hdr_last;
  logic          len_bad;
  logic          port_match;
  logic          pay_last;

  always_comb begin
    ready_out      = 1'b1;
    data_out       = '0;
    data_valid_out = 1'b0;
    if (state == FWD) begin
      ready_out      = ready_in;
      data_out       = data_in;
      data_valid_out = data_valid_in;
    end
  end

  // Only 7 bytes need storing; the 8th is taken straight from data_in.
  assign hdr_next   = udp_hdr_t'({hdr_shift, data_in});
  assign accept     = data_valid_in && ready_out;
  assign hdr_last   = (state == HDR) && accept && (hdr_cnt == 3'(UDP_HDR_BYTES - 1));
  assign len_bad    = hdr_next.length < MIN_LEN;
  assign port_match = (FILTER_PORT == 16'd0) || (hdr_next.dst_port == FILTER_PORT);
  assign pay_last   = pay_cnt == (udp_length - 16'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HDR;
      hdr_cnt      <= '0;
      hdr_shift    <= '0;
      pay_cnt      <= '0;
      header_done  <= 1'b0;
      hdr_error    <= 1'b0;
      fwd_enable   <= 1'b0;
      drop_enable  <= 1'b0;
      src_port     <= '0;
      dst_port     <= '0;
      udp_length   <= '0;
      udp_checksum <= '0;
    end else begin
      header_done <= 1'b0;
      hdr_error   <= 1'b0;
      case (state)
        HDR: begin
          if (accept) begin
            hdr_shift <= {hdr_shift[47:0], data_in};
            hdr_cnt   <= hdr_cnt + 3'd1;
          end
          if (hdr_last) begin
            if (len_bad) begin
              hdr_error <= 1'b1;
            end else begin
              header_done  <= 1'b1;
              src_port     <= hdr_next.src_port;
              dst_port     <= hdr_next.dst_port;
              udp_length   <= hdr_next.length;
              udp_checksum <= hdr_next.checksum;
              if (hdr_next.length != 16'(UDP_HDR_BYTES)) begin
                if (port_match) begin
                  state      <= FWD;
                  fwd_enable <= 1'b1;
                end else begin
                  state       <= DROP;
                  drop_enable <= 1'b1;
                end
              end
            end
          end
        end
        FWD, DROP: begin
          if (accept) begin
            if (pay_last) begin
              state       <= HDR;
              pay_cnt     <= '0;
              fwd_enable  <= 1'b0;
              drop_enable <= 1'b0;
            end else begin
              pay_cnt <= pay_cnt + 16'd1;
            end
          end
        end
        default: state <= HDR;
      endcase
    end
  end

`ifdef UDP_PARSER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_fwd_cnt  <= '0;
      pkt_drop_cnt <= '0;
      pkt_err_cnt  <= '0;
    end else if (hdr_last) begin
      if (len_bad) begin
        if (pkt_err_cnt != '1) pkt_err_cnt <= pkt_err_cnt + 32'd1;
      end else if (port_match) begin
        if (pkt_fwd_cnt != '1) pkt_fwd_cnt <= pkt_fwd_cnt + 32'd1;
      end else begin
        if (pkt_drop_cnt != '1) pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_udp_header_parser.sv
// Directed bench for udp_header_parser; payload bytes are checked through a scoreboard queue.
module tb_udp_header_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = '0;
  logic        data_valid_in = 1'b0;
  logic        ready_out;
  logic        ready_in = 1'b1;
  logic [7:0]  data_out;
  logic        data_valid_out;
  logic        header_done;
  logic        hdr_error;
  logic        fwd_enable;
  logic        drop_enable;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [15:0] udp_length;
  logic [15:0] udp_checksum;
`ifdef UDP_PARSER_STATS_EN
  logic [31:0] pkt_fwd_cnt;
  logic [31:0] pkt_drop_cnt;
  logic [31:0] pkt_err_cnt;
`endif

  udp_header_parser dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
    .ready_out      (ready_out),
    .ready_in       (ready_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .header_done    (header_done),
    .hdr_error      (hdr_error),
    .fwd_enable     (fwd_enable),
    .drop_enable    (drop_enable),
    .src_port       (src_port),
    .dst_port       (dst_port),
    .udp_length     (udp_length),
    .udp_checksum   (udp_checksum)
`ifdef UDP_PARSER_STATS_EN
    ,
    .pkt_fwd_cnt    (pkt_fwd_cnt),
    .pkt_drop_cnt   (pkt_drop_cnt),
    .pkt_err_cnt    (pkt_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  int         last_wait;
  logic       last_dv;
  logic [7:0] exp_q[$];
  int         exp_fwd = 0;
  int         exp_drop = 0;
  int         exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte until accepted; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    data_in       = b;
    data_valid_in = 1'b1;
    last_wait     = 0;
    last_dv       = 1'b0;
    do begin
      @(negedge clk);
      acc     = ready_out;
      last_dv = last_dv | data_valid_out;
      @(posedge clk);
      #1;
      last_wait++;
    end while (!acc && last_wait < 50);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    data_valid_in = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [15:0] c);
    logic [63:0] h;
    h = {s, d, l, c};
    for (int i = 0; i < 8; i++) send_byte(h[63-8*i -: 8]);
  endtask

  task automatic chk_fields(input string tag, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input logic [15:0] c);
    chk({tag, "_src"},  32'(src_port),     32'(s));
    chk({tag, "_dst"},  32'(dst_port),     32'(d));
    chk({tag, "_len"},  32'(udp_length),   32'(l));
    chk({tag, "_csum"}, 32'(udp_checksum), 32'(c));
  endtask

  task automatic chk_stats(input string tag);
`ifdef UDP_PARSER_STATS_EN
    chk({tag, "_fwd_cnt"},  pkt_fwd_cnt,  32'(exp_fwd));
    chk({tag, "_drop_cnt"}, pkt_drop_cnt, 32'(exp_drop));
    chk({tag, "_err_cnt"},  pkt_err_cnt,  32'(exp_err));
`endif
  endtask

  always @(negedge clk) begin
    if (!rst && data_valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'(data_valid_out), 32'd0);
      end else begin
        chk("sb_payload", 32'(data_out), 32'(exp_q.pop_front()));
        rx_cnt++;
      end
    end
  end

  initial begin
    logic [7:0] pay[4];
    int         pat[6];
    int         idx;
    logic       acc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_header_done", 32'(header_done), 32'd0);
    chk("rst_hdr_error", 32'(hdr_error), 32'd0);
    chk("rst_fwd", 32'(fwd_enable), 32'd0);
    chk("rst_drop", 32'(drop_enable), 32'd0);
    chk("rst_dv_out", 32'(data_valid_out), 32'd0);
    chk_fields("rst", 16'h0, 16'h0, 16'h0, 16'h0);
    chk_stats("rst");
    rst = 1'b0;

    // Forwarded packet, 4-byte payload
    send_hdr(16'h1388, 16'h1388, 16'h000C, 16'hABCD);
    exp_fwd++;
    chk("p1_header_done", 32'(header_done), 32'd1);
    chk("p1_fwd", 32'(fwd_enable), 32'd1);
    chk("p1_drop", 32'(drop_enable), 32'd0);
    chk_fields("p1", 16'h1388, 16'h1388, 16'h000C, 16'hABCD);
    chk_stats("p1");
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pay[i]);
      if (i == 1) chk("p1_header_done_pulse", 32'(header_done), 32'd0);
      send_byte(pay[i]);
      if (i == 2) chk("p1_fwd_mid", 32'(fwd_enable), 32'd1);
    end
    chk("p1_fwd_after", 32'(fwd_enable), 32'd0);

    // Dropped packet
    send_hdr(16'h1388, 16'h0035, 16'h000C, 16'hABCD);
    exp_drop++;
    chk("p2_header_done", 32'(header_done), 32'd1);
    chk("p2_drop", 32'(drop_enable), 32'd1);
    chk("p2_fwd", 32'(fwd_enable), 32'd0);
    chk_stats("p2");
    for (int i = 0; i < 4; i++) begin
      send_byte(pay[i]);
      chk("p2_ready_held", 32'(last_wait), 32'd1);
      chk("p2_no_dv_out", 32'(last_dv), 32'd0);
    end
    chk("p2_drop_after", 32'(drop_enable), 32'd0);

    // Empty payload
    send_hdr(16'h2222, 16'h1388, 16'h0008, 16'h0000);
    exp_fwd++;
    chk("p3_header_done", 32'(header_done), 32'd1);
    chk("p3_fwd", 32'(fwd_enable), 32'd0);
    chk("p3_drop", 32'(drop_enable), 32'd0);
    chk_fields("p3", 16'h2222, 16'h1388, 16'h0008, 16'h0000);

    // Malformed length
    send_hdr(16'h7777, 16'h1388, 16'h0005, 16'h1234);
    exp_err++;
    chk("p4_hdr_error", 32'(hdr_error), 32'd1);
    chk("p4_header_done", 32'(header_done), 32'd0);
    chk("p4_fwd", 32'(fwd_enable), 32'd0);
    chk_fields("p4_hold", 16'h2222, 16'h1388, 16'h0008, 16'h0000);
    chk_stats("p4");
    @(posedge clk);
    #1;
    chk("p4_err_pulse", 32'(hdr_error), 32'd0);

    // Forward with backpressure
    send_hdr(16'h0102, 16'h1388, 16'h000C, 16'h5566);
    exp_fwd++;
    chk("p5_fwd", 32'(fwd_enable), 32'd1);
    chk_fields("p5", 16'h0102, 16'h1388, 16'h000C, 16'h5566);
    pay = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 4; i++) exp_q.push_back(pay[i]);
    pat = '{1, 0, 0, 1, 1, 1};
    idx = 0;
    for (int c = 0; c < 6 && idx < 4; c++) begin
      ready_in      = (pat[c] != 0);
      data_in       = pay[idx];
      data_valid_in = 1'b1;
      @(negedge clk);
      chk("p5_ready_mirror", 32'(ready_out), 32'(ready_in));
      acc = ready_out;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (c == 2) chk("p5_fwd_stalled", 32'(fwd_enable), 32'd1);
    end
    data_valid_in = 1'b0;
    ready_in      = 1'b1;
    chk("p5_bytes_accepted", 32'(idx), 32'd4);
    chk("p5_fwd_after", 32'(fwd_enable), 32'd0);

    // Reset in the middle of a 10-byte payload
    send_hdr(16'h0A0A, 16'h1388, 16'h0012, 16'hFFFF);
    exp_fwd++;
    chk("p6_fwd", 32'(fwd_enable), 32'd1);
    chk_stats("p6");
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h60 + 8'(i));
      send_byte(8'h60 + 8'(i));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_fwd = 0;
    exp_drop = 0;
    exp_err = 0;
    chk("p6_rst_fwd", 32'(fwd_enable), 32'd0);
    chk("p6_rst_drop", 32'(drop_enable), 32'd0);
    chk("p6_rst_dv_out", 32'(data_valid_out), 32'd0);
    chk("p6_rst_ready", 32'(ready_out), 32'd1);
    chk_fields("p6_rst", 16'h0, 16'h0, 16'h0, 16'h0);
    chk_stats("p6_rst");

    send_hdr(16'hBEEF, 16'h0999, 16'h0008, 16'h4242);
    exp_drop++;
    chk("p7_header_done", 32'(header_done), 32'd1);
    chk("p7_hdr_error", 32'(hdr_error), 32'd0);
    chk("p7_drop", 32'(drop_enable), 32'd0);
    chk_fields("p7", 16'hBEEF, 16'h0999, 16'h0008, 16'h4242);
    chk_stats("p7");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_rx_count", 32'(rx_cnt), 32'd11);
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_header_parser.md
Name: udp_header_parser

Overview:
- Byte-stream stage directly upstream of the payload forwarder.
- Consumes the 8-byte UDP header (src port, dst port, length, checksum; big-endian) and latches the fields.
- Filters on destination port and drives fwd_enable/drop_enable/header_done/udp_length to the forwarder.
- Passes payload bytes through, and counts them to find the packet boundary, then rearms for the next header.

Parameters:
- FILTER_PORT, 16'd5000, destination port to forward; 16'd0 = wildcard (forward all).
- MIN_LEN, 16'd8, smallest legal udp_length; below this the header is malformed.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_in  in  8  input byte stream
- data_valid_in  in  1  data_in valid
- ready_out  out  1  parser accepts a byte this cycle
- ready_in  in  1  forwarder ready (forwarder's ready_out)
- data_out  out  8  payload byte to forwarder
- data_valid_out  out  1  payload byte valid
- header_done  out  1  one-cycle pulse: legal header captured
- hdr_error  out  1  one-cycle pulse: malformed header
- fwd_enable  out  1  current payload is forwarded
- drop_enable  out  1  current payload is discarded
- src_port  out  16  latched source port
- dst_port  out  16  latched destination port
- udp_length  out  16  latched UDP length (header + payload)
- udp_checksum  out  16  latched checksum (not verified)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on rst; sampled only on the rising edge of clk.
- Reset: state=HDR, byte counters=0, all outputs 0 (all fields 0, all enables 0, all pulses 0).
- Reset mid-packet aborts the packet. The next accepted byte is header byte 0.
- Transfer: a byte is accepted when data_valid_in && ready_out.
- States (registered): HDR, FWD, DROP.
- HDR:
  - ready_out=1, data_valid_out=0, fwd_enable=drop_enable=0.
  - hdr_cnt (3-bit) indexes accepted bytes 0..7, shifted into a 64-bit register, MSB first.
  - Byte order: bytes 0-1 src_port, 2-3 dst_port, 4-5 length, 6-7 checksum.
- On acceptance of byte 7, the next cycle:
  - Fields update together. They hold until the next byte-7 acceptance. Partial headers never alter the outputs.
  - length < MIN_LEN: hdr_error=1 for one cycle, header_done=0, stay HDR.
  - length == 8: header_done=1, enables stay 0, stay HDR (empty payload).
  - Otherwise: header_done=1. If dst_port==FILTER_PORT or FILTER_PORT==0, go FWD (fwd_enable=1); else go DROP (drop_enable=1).
  - Header-to-enable latency is 1 cycle after byte 7.
- FWD:
  - data_out=data_in, data_valid_out=data_valid_in, ready_out=ready_in (combinational passthrough).
  - fwd_enable=1.
- DROP:
  - ready_out=1, data_valid_out=0, drop_enable=1. Bytes are consumed and discarded.
- Payload counting (FWD/DROP):
  - pay_cnt (16-bit) counts accepted bytes.
  - When a byte is accepted with pay_cnt == udp_length-9, the next state is HDR and pay_cnt=0.
  - Enables deassert the cycle after the last payload byte.
- Arithmetic: all 16-bit unsigned. The payload limit is udp_length-8, guaranteed ≥1 in FWD/DROP, so there is no wrap.
- Stall: data_valid_in low or ready_in low holds all counters and state.
- No header bytes are accepted while in FWD/DROP; back-to-back packets are separated only by state.

Optional Feature:
- Macro UDP_PARSER_STATS_EN.
- When defined, adds outputs pkt_fwd_cnt, pkt_drop_cnt and pkt_err_cnt (32 bits each).
  - Each increments on the cycle header_done/hdr_error is pulsed, according to the decision taken.
  - An empty packet (length 8) counts as forwarded when the port matches, dropped otherwise.
  - Counters saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package udp_pkg:
  - UDP_HDR_BYTES=8.
  - Byte offset constants.
  - Typedef parser_state_t (HDR, FWD, DROP).
  - Packed struct udp_hdr_t {src_port, dst_port, length, checksum}.
- No sub-module needed. Capture, FSM and counters live in one module.

Test Plan:
- Header 13 88 13 88 00 0C AB CD, then payload 11 22 33 44:
  - header_done one cycle after byte 7; dst_port=0x1388; fwd_enable=1.
  - 4 bytes appear on data_out.
  - State returns to HDR after byte 0x44; fwd_enable=0 next cycle.
- Same packet with dst 0x0035: drop_enable=1, ready_out held 1, data_valid_out never 1, 4 bytes consumed, back to HDR.
- length 0x0008: header_done pulse with both enables 0. Next packet parses correctly from the following byte.
- length 0x0005: hdr_error pulse, no header_done, field outputs keep the previous packet's values, parser stays in HDR.
- FWD with ready_in toggled 1,0,0,1 during payload: ready_out mirrors ready_in, pay_cnt holds while stalled, all bytes delivered once and in order.
- rst asserted after 3 payload bytes of a 10-byte payload: all outputs 0 next cycle. A following full header is parsed correctly, with stats counters (if enabled) reset to 0.
